// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: variable-latency imem request/response with an in-order queue to decode.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instruction_fetch_queue #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  PC_out,
    output logic [ADDR_W-1:0]  PC_inc_out,
    output logic               if_valid,
    input  logic               if_ready,
    input  logic               or_out,
    input  logic [ADDR_W-1:0]  add_pc,
    input  logic               Branchreg,
    input  logic [ADDR_W-1:0]  read_data_1,
    output logic               fault
);
    localparam int unsigned       PTR_W = $clog2(DEPTH);
    localparam int unsigned       CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INC   = ADDR_W'(4);

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic               issue_blocked, has_credit, issue, keep, pop, load_head;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem [DEPTH];
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc_q;

    assign redirect = Branchreg | or_out;
    assign target   = Branchreg ? read_data_1 : add_pc;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= |target[1:0];
        end
    end

    assign issue_blocked = fault_q;
    assign fault         = fault_q;
`else
    assign issue_blocked = 1'b0;
    assign fault         = 1'b0;
`endif

    // Credits cover both queued entries and in-flight requests, so a push can never overflow.
    assign has_credit = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH);
    assign imem_req_valid = reset && !redirect && !issue_blocked && has_credit;
    assign imem_addr      = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign keep           = imem_resp_valid && (drop_q == '0) && !redirect;
    assign if_valid       = (count_q != '0);
    assign pop            = if_valid && if_ready && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            fetch_pc_d    = target;
            resp_pc_d     = target;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            outstanding_d = outstanding_q - CNT_W'(imem_resp_valid);
            // Every request still in flight after this cycle belongs to the old stream.
            drop_d        = outstanding_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + INC;
            end
            outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_resp_valid);
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (keep) begin
                resp_pc_d = resp_pc_q + INC;
                tail_d    = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(keep) - CNT_W'(pop);
        end
    end

    // Head outputs are registered: load whichever entry becomes the head next cycle.
    always_comb begin
        load_head = !redirect && (count_d != '0);
        if (count_q == CNT_W'(pop)) begin
            instr_d = imem_resp_data;
            pc_d    = resp_pc_q;
        end else begin
            instr_d = data_mem[head_d];
            pc_d    = pc_mem[head_d];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            instr_q       <= '0;
            pc_q          <= '0;
            pc_inc_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (load_head) begin
                instr_q  <= instr_d;
                pc_q     <= pc_d;
                pc_inc_q <= pc_d + INC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (keep) begin
            data_mem[tail_q] <= imem_resp_data;
            pc_mem[tail_q]   <= resp_pc_q;
        end
    end

    assign instruction_out = instr_q;
    assign PC_out          = pc_q;
    assign PC_inc_out      = pc_inc_q;

endmodule
